// File: rtl/data_mem_sync.sv
`default_nettype none
// ============================================================================
// Module : data_mem_sync
// Byte-addressable RV32I load/store memory with valid/ready request and
// response channels and a fixed, configurable access latency.
// Rev    : 1.0
// ============================================================================
module data_mem_sync #(
    parameter int ADDR_W           = 16,
    parameter int LATENCY          = 1,
    parameter int ALLOW_MISALIGNED = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  mem_q [0:(2**ADDR_W)-1];

    logic              w_sel_in;
    logic              w_accept;
    logic              w_access;
    logic              w_we;
    logic [2:0]        w_f3;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic [1:0]        w_size_m1;
    logic [3:0]        w_be;
    logic [32:0]       w_last;
    logic              w_oor;
    logic              w_bad_f3;
    logic              w_misal;
    logic              w_err;
    logic [31:0]       w_rdata;
    logic [ADDR_W-1:0] w_idx  [4];
    logic [7:0]        w_byte [4];

    // With LATENCY=1 the access happens on the accept edge, so operands come
    // straight from the request port while idle and from the latch otherwise.
    assign w_sel_in = (state_q == c_IDLE);
    assign w_we     = w_sel_in ? req_we_i     : we_q;
    assign w_f3     = w_sel_in ? req_funct3_i : f3_q;
    assign w_addr   = w_sel_in ? req_addr_i   : addr_q;
    assign w_wdata  = w_sel_in ? req_wdata_i  : wdata_q;

    assign w_accept = rst_n && w_sel_in && req_valid_i;
    assign w_access = rst_n && ((w_accept && (LATENCY == 1)) ||
                                ((state_q == c_WAIT) && (cnt_q == 4'd1)));

    always_comb begin
        w_size_m1 = 2'd3;
        w_be      = 4'b1111;
        case (w_f3[1:0])
            2'd0:    begin w_size_m1 = 2'd0; w_be = 4'b0001; end
            2'd1:    begin w_size_m1 = 2'd1; w_be = 4'b0011; end
            default: ;
        endcase
    end

    // Last byte computed in 33 bits so accesses near 2^32 cannot wrap to 0.
    assign w_last   = {1'b0, w_addr} + {31'd0, w_size_m1};
    assign w_oor    = |(w_last >> ADDR_W);
    assign w_bad_f3 = w_we ? (w_f3[2] || (w_f3[1:0] == 2'd3))
                           : ((w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7));
    assign w_misal  = ((w_f3[1:0] == 2'd1) && w_addr[0]) ||
                      ((w_f3[1:0] == 2'd2) && (w_addr[1:0] != 2'd0));
    assign w_err    = w_bad_f3 || w_oor || ((ALLOW_MISALIGNED == 0) && w_misal);

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign w_idx[k]  = w_addr[ADDR_W-1:0] + ADDR_W'(k);
            assign w_byte[k] = mem_q[w_idx[k]];
        end
    endgenerate

    always_comb begin
        w_rdata = 32'd0;
        if (!w_err && !w_we) begin
            case (w_f3)
                3'd0:    w_rdata = {{24{w_byte[0][7]}}, w_byte[0]};
                3'd1:    w_rdata = {{16{w_byte[1][7]}}, w_byte[1], w_byte[0]};
                3'd2:    w_rdata = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
                3'd4:    w_rdata = {24'd0, w_byte[0]};
                3'd5:    w_rdata = {16'd0, w_byte[1], w_byte[0]};
                default: w_rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_access && w_we && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    mem_q[w_idx[k]] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (w_access) begin
                rdata_q <= w_rdata;
                err_q   <= w_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (req_valid_i) begin
                    if (LATENCY == 1) begin
                        state_d = c_RESP;
                    end else begin
                        state_d = c_WAIT;
                        cnt_d   = c_LAT_M1;
                    end
                end
            end
            c_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = c_RESP;
                end
            end
            c_RESP: begin
                if (rsp_ready_i) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = rst_n && (state_q == c_IDLE);
        rsp_valid_o = (state_q == c_RESP);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_sync.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_sync
// Bench for data_mem_sync: a LATENCY=1 strict-alignment instance and a
// LATENCY=4 misaligned-allowed instance checked against a byte-map model.
// Rev    : 1.0
// ============================================================================
module tb_data_mem_sync;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [2:0]  req_f3    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] obs_rd;
    logic        obs_err;
    logic [7:0]  mdl [longint];

    always #5 clk = ~clk;

    data_mem_sync #(.ADDR_W(16), .LATENCY(1), .ALLOW_MISALIGNED(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_funct3_i(req_f3[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    data_mem_sync #(.ADDR_W(16), .LATENCY(4), .ALLOW_MISALIGNED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_funct3_i(req_f3[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    function automatic int lat(input int s);
        return (s == 0) ? 1 : 4;
    endfunction

    function automatic longint key(input int s, input longint a);
        return (longint'(s) << 40) + a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: 1/2/4-byte accesses on a sparse byte map; instance 1 allows misalignment.
    task automatic model(input int s, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic e_err, output logic [31:0] e_rd, output logic known);
        int     size;
        longint last;
        longint v;
        longint a;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we) e_err = !(f3 inside {3'd0, 3'd1, 3'd2});
        else    e_err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        last = longint'(addr) + longint'(size) - 1;
        if (last >= 65536) e_err = 1'b1;
        if (s == 0 && (longint'(addr) % size) != 0) e_err = 1'b1;
        e_rd  = 32'd0;
        known = 1'b1;
        v     = 0;
        if (!e_err) begin
            for (int k = 0; k < size; k++) begin
                a = key(s, longint'(addr) + k);
                if (we) mdl[a] = wd[8*k +: 8];
                else if (mdl.exists(a)) v += longint'(mdl[a]) << (8 * k);
                else known = 1'b0;
            end
            if (!we) begin
                if (f3 == 3'd0 && v >= 128)   v -= 256;
                if (f3 == 3'd1 && v >= 32768) v -= 65536;
                e_rd = v[31:0];
            end
        end
    endtask

    task automatic txn(input int s, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic        e_err;
        logic        known;
        logic [31:0] e_rd;
        logic        rdy_seen;
        int          n;
        model(s, we, f3, addr, wd, e_err, e_rd, known);
        @(negedge clk);
        n = 0;
        while (req_ready[s] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(req_ready[s]), 32'd1);
        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_f3[s]    = f3;
        req_addr[s]  = addr;
        req_wdata[s] = wd;
        rsp_ready[s] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        n = 0;
        rdy_seen = 1'b0;
        while (rsp_valid[s] !== 1'b1 && n < 40) begin
            if (req_ready[s] !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("rsp_latency", 32'(n), 32'(lat(s) - 1));
        check("req_ready_busy", 32'(rdy_seen | req_ready[s]), 32'd0);
        check("rsp_err", 32'(rsp_err[s]), 32'(e_err));
        if (known || e_err) check("rsp_rdata", rsp_rdata[s], e_rd);
        obs_rd  = rsp_rdata[s];
        obs_err = rsp_err[s];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid[s]), 32'd1);
            check("stall_ready", 32'(req_ready[s]), 32'd0);
            if (known || e_err) check("stall_rdata", rsp_rdata[s], e_rd);
        end
        rsp_ready[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[s] = 1'b0;
        check("rsp_drop", 32'(rsp_valid[s]), 32'd0);
        check("back_idle", 32'(req_ready[s]), 32'd1);
    endtask

    initial begin
        int          s;
        int          r;
        logic [31:0] ra;
        logic        rwe;
        logic [2:0]  rf3;

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_f3[i]    = 3'd0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            rsp_ready[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready", 32'(req_ready[i]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
            check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
        end
        rst_n = 1'b1;

        // LATENCY=1, strict alignment
        txn(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        check("sw_rdata_zero", obs_rd, 32'd0);
        txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 0);
        check("lw_10", obs_rd, 32'hDEADBEEF);
        txn(0, 1'b0, 3'd0, 32'h13, 32'd0, 0);
        check("lb_13", obs_rd, 32'hFFFFFFDE);
        txn(0, 1'b0, 3'd4, 32'h13, 32'd0, 0);
        check("lbu_13", obs_rd, 32'h000000DE);
        txn(0, 1'b0, 3'd1, 32'h12, 32'd0, 0);
        check("lh_12", obs_rd, 32'hFFFFDEAD);
        txn(0, 1'b0, 3'd5, 32'h10, 32'd0, 0);
        check("lhu_10", obs_rd, 32'h0000BEEF);
        txn(0, 1'b1, 3'd0, 32'h11, 32'h00000055, 0);
        txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 0);
        check("lw_after_sb", obs_rd, 32'hDEAD55EF);
        txn(0, 1'b1, 3'd1, 32'h12, 32'h00001234, 0);
        txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 0);
        check("lw_after_sh", obs_rd, 32'h123455EF);
        txn(0, 1'b0, 3'd2, 32'h11, 32'd0, 0);
        check("lw_misal_err", 32'(obs_err), 32'd1);
        check("lw_misal_rdata", obs_rd, 32'd0);
        txn(0, 1'b1, 3'd2, 32'h12, 32'hCAFEF00D, 0);
        check("sw_misal_err", 32'(obs_err), 32'd1);
        txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 0);
        check("lw_unchanged", obs_rd, 32'h123455EF);
        txn(0, 1'b0, 3'd3, 32'h10, 32'd0, 0);
        check("ld_f3_3_err", 32'(obs_err), 32'd1);
        txn(0, 1'b0, 3'd0, 32'h10000, 32'd0, 0);
        check("lb_oor_err", 32'(obs_err), 32'd1);
        txn(0, 1'b1, 3'd4, 32'h10, 32'h0, 0);
        check("st_f3_4_err", 32'(obs_err), 32'd1);

        // LATENCY=4, misaligned permitted
        txn(1, 1'b0, 3'd2, 32'hFFFE, 32'd0, 0);
        check("lw_top_err", 32'(obs_err), 32'd1);
        txn(1, 1'b1, 3'd2, 32'h20, 32'h11111111, 0);
        txn(1, 1'b1, 3'd2, 32'h24, 32'h44332211, 0);
        txn(1, 1'b0, 3'd2, 32'h22, 32'd0, 0);
        check("lw_misal_ok", obs_rd, 32'h22111111);
        txn(1, 1'b0, 3'd2, 32'h20, 32'd0, 3);
        check("lw_stall", obs_rd, 32'h11111111);

        // Store aborted by reset while waiting
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_f3[1]    = 3'd2;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_rdata", rsp_rdata[1], 32'h11111111);
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("arst_rsp_rdata", rsp_rdata[1], 32'd0);
        check("arst_req_ready", 32'(req_ready[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("aborted_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        txn(1, 1'b0, 3'd2, 32'h20, 32'd0, 0);
        check("lw_after_abort", obs_rd, 32'h11111111);

        // Randomized traffic on a pre-filled window plus top-of-memory edges
        for (int si = 0; si < 2; si++) begin
            for (int a = 0; a < 64; a += 4) begin
                txn(si, 1'b1, 3'd2, 32'h100 + 32'(a), $urandom, 0);
            end
        end
        for (int i = 0; i < 60; i++) begin
            s   = int'($urandom % 2);
            r   = int'($urandom % 10);
            if (r == 0)      ra = 32'hFFFC + ($urandom % 4);
            else if (r == 1) ra = 32'hFFFF_FFFC + ($urandom % 4);
            else if (r == 2) ra = 32'h10000 + ($urandom % 4);
            else             ra = 32'h100 + ($urandom % 64);
            rwe = (($urandom % 3) == 0);
            rf3 = 3'($urandom % 8);
            txn(s, rwe, rf3, ra, $urandom, int'($urandom % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
